mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Arbitrates a core's instruction-fetch and data ports onto a
//                single shared external bus. It takes one transfer at a time
//                through IDLE -> XFER -> DONE. On a tie it grants whichever
//                requester was not served last.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst_n                 clock, asynchronous active-low reset
//    ireq, IAD                  fetch request and address (in)
//    IDT, ACKI_n                fetched instruction (registered), fetch ack
//    MREQ, WRITE, SIZE, DAD     data request, direction, size, address (in)
//    dwdata                     store data (in)
//    drdata, ACKD_n             load data (registered), data ack
//    BAD, BREQ, BWRITE, BSIZE   external bus address and control (out)
//    BDT_out, BDT_oe            external bus write data and its enable
//    BDT_in, BACK_n             external bus read data and transfer-done
//    bus_err                    one-cycle pulse when a transfer is aborted
//
//  Configuration macro
//    BUS_TIMEOUT_EN  when defined, a transfer aborts after TIMEOUT_CYCLES
//                    wait states. It completes with read data 0 and bus_err.
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ireq,
  input  logic [31:0] IAD,
  output logic [31:0] IDT,
  output logic        ACKI_n,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  input  logic [31:0] DAD,
  input  logic [31:0] dwdata,
  output logic [31:0] drdata,
  output logic        ACKD_n,
  output logic [31:0] BAD,
  output logic        BREQ,
  output logic        BWRITE,
  output logic [1:0]  BSIZE,
  output logic [31:0] BDT_out,
  output logic        BDT_oe,
  input  logic [31:0] BDT_in,
  input  logic        BACK_n,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last_data;   // 1 = data port was served last
  logic        r_gnt_data;    // 1 = current transfer belongs to data port
  logic [31:0] r_bad;
  logic [31:0] r_bdt_out;
  logic [31:0] r_idt;
  logic [31:0] r_drdata;
  logic        r_bwrite;
  logic [1:0]  r_bsize;
  logic        r_bus_err;
  logic        w_start;
  logic        w_pick_data;
  logic        w_ack;
  logic        w_abort;

  // Request selection. On a tie, grant the port that was not served last.
  always_comb begin
    w_start     = 1'b0;
    w_pick_data = 1'b0;
    if (ireq && MREQ) begin
      w_start     = 1'b1;
      w_pick_data = ~r_last_data;
    end else if (MREQ) begin
      w_start     = 1'b1;
      w_pick_data = 1'b1;
    end else if (ireq) begin
      w_start     = 1'b1;
    end
  end

  // A slave completion in the limit cycle takes priority over the abort.
  assign w_ack = (r_state == XFER) && !BACK_n;

`ifdef BUS_TIMEOUT_EN
  localparam logic [15:0] c_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state == IDLE && w_start) begin
      r_wait_cnt <= '0;
    end else if (r_state == XFER && BACK_n) begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end

  // Abort in the wait state that would bring the count up to the limit.
  assign w_abort = (r_state == XFER) && BACK_n && (r_wait_cnt == c_LIMIT);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign w_abort          = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = XFER;
      XFER:    if (w_ack || w_abort) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bus registers, read-data capture, and arbitration history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_data <= 1'b0;
      r_gnt_data  <= 1'b0;
      r_bad       <= '0;
      r_bdt_out   <= '0;
      r_bwrite    <= 1'b0;
      r_bsize     <= '0;
      r_idt       <= '0;
      r_drdata    <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_gnt_data <= w_pick_data;
            if (w_pick_data) begin
              r_bad     <= DAD;
              r_bwrite  <= WRITE;
              r_bsize   <= SIZE;
              r_bdt_out <= dwdata;
            end else begin
              r_bad     <= IAD;
              r_bwrite  <= 1'b0;
              r_bsize   <= 2'b10;
              r_bdt_out <= '0;
            end
          end
        end
        XFER: begin
          if (w_ack) begin
            r_last_data <= r_gnt_data;
            if (!r_gnt_data)    r_idt    <= BDT_in;
            else if (!r_bwrite) r_drdata <= BDT_in;
          end else if (w_abort) begin
            r_last_data <= r_gnt_data;
            r_bus_err   <= 1'b1;
            if (!r_gnt_data)    r_idt    <= '0;
            else if (!r_bwrite) r_drdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign BREQ    = (r_state == XFER);
  assign BDT_oe  = (r_state == XFER) && r_bwrite;
  assign ACKI_n  = !((r_state == DONE) && !r_gnt_data);
  assign ACKD_n  = !((r_state == DONE) &&  r_gnt_data);
  assign BAD     = r_bad;
  assign BWRITE  = r_bwrite;
  assign BSIZE   = r_bsize;
  assign BDT_out = r_bdt_out;
  assign IDT     = r_idt;
  assign drdata  = r_drdata;
  assign bus_err = r_bus_err;

endmodule

`default_nettype wire
